// File: rtl/pc16_callstack.sv
// -----------------------------------------------------------------------------
// pc16_callstack
// Registered program counter with a hardware return-address stack for the
// instruction-fetch path. On each rising edge it executes the highest-priority
// asserted command: ret > call > load > inc > hold.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset (clears out, depth, err)
//   in     : jump / call target address
//   load   : jump, out <= in
//   inc    : advance, out <= out + 1 (wraps)
//   call   : push out+1 onto the stack, then out <= in
//   ret    : pop the top stack entry into out
//   out    : current program counter (registered)
//   depth  : number of valid stack entries (registered)
//   empty  : depth == 0
//   full   : depth == DEPTH
//   err    : sticky overflow / underflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module pc16_callstack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] ADDR_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ADDR_ONE  = WIDTH'(1);
    localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    CNT_FULL  = CW'(DEPTH);

    // Return-address storage; deliberately not reset, entries above depth
    // are never observed.
    logic [WIDTH-1:0] stack_r [DEPTH];

    logic [WIDTH-1:0] out_r;
    logic [CW-1:0]    depth_r;
    logic             err_r;
    logic             empty_r;
    logic             full_r;

    logic [WIDTH-1:0] out_s;
    logic [CW-1:0]    depth_s;
    logic             err_s;
    logic             push_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic [CW-1:0]    top_cnt_s;
    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    push_idx_s;

    // Next-state decode: prioritised command selection and stack addressing.
    always_comb begin
        out_s      = out_r;
        depth_s    = depth_r;
        err_s      = err_r;
        push_s     = 1'b0;
        ret_addr_s = out_r + ADDR_ONE;      // carry out is discarded
        top_cnt_s  = depth_r - CNT_ONE;
        // When depth is zero the top index aliases a valid slot, but the read
        // is only used when depth is non-zero.
        top_idx_s  = top_cnt_s[AW-1:0];
        push_idx_s = depth_r[AW-1:0];

        if (ret) begin
            if (depth_r != CNT_ZERO) begin
                out_s   = stack_r[top_idx_s];
                depth_s = top_cnt_s;
            end else begin
                err_s   = 1'b1;             // underflow: nothing else changes
            end
        end else if (call) begin
            if (depth_r != CNT_FULL) begin
                push_s  = 1'b1;
                out_s   = in;
                depth_s = depth_r + CNT_ONE;
            end else begin
                err_s   = 1'b1;             // overflow: the whole call is rejected
            end
        end else if (load) begin
            out_s = in;
        end else if (inc) begin
            out_s = out_r + ADDR_ONE;
        end else begin
            out_s = out_r;
        end
    end

    // Stack write port; gated by reset so edges during reset have no effect.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            stack_r[push_idx_s] <= ret_addr_s;
        end
    end

    // Architectural state; empty/full are registered decodes of the next depth
    // so they stay aligned with depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r   <= ADDR_ZERO;
            depth_r <= CNT_ZERO;
            err_r   <= 1'b0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            out_r   <= out_s;
            depth_r <= depth_s;
            err_r   <= err_s;
            empty_r <= (depth_s == CNT_ZERO);
            full_r  <= (depth_s == CNT_FULL);
        end
    end

    assign out   = out_r;
    assign depth = depth_r;
    assign empty = empty_r;
    assign full  = full_r;
    assign err   = err_r;

endmodule

// File: tb/tb_pc16_callstack.sv
module tb_pc16_callstack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in = '0;
    logic             load = 1'b0;
    logic             inc = 1'b0;
    logic             call = 1'b0;
    logic             ret = 1'b0;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             err;

    pc16_callstack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc),
        .call(call), .ret(ret), .out(out), .depth(depth),
        .empty(empty), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Behavioural reference: a queue of return addresses and a PC value.
    logic [WIDTH-1:0] m_out;
    logic [WIDTH-1:0] m_stk[$];
    bit               m_err;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = '0;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic model_apply();
        if (ret) begin
            if (m_stk.size() > 0) m_out = m_stk.pop_back();
            else m_err = 1'b1;
        end else if (call) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(m_out + 16'd1);
                m_out = in;
            end else begin
                m_err = 1'b1;
            end
        end else if (load) begin
            m_out = in;
        end else if (inc) begin
            m_out = m_out + 16'd1;
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out",   32'(out),   32'(m_out));
            chk("depth", 32'(depth), 32'(m_stk.size()));
            chk("empty", 32'(empty), 32'(m_stk.size() == 0));
            chk("full",  32'(full),  32'(m_stk.size() == DEPTH));
            chk("err",   32'(err),   32'(m_err));
        end
    end

    task automatic step(input logic l, input logic i, input logic c, input logic r,
                        input logic [WIDTH-1:0] a);
        @(negedge clk);
        #1;
        load = l; inc = i; call = c; ret = r; in = a;
        @(posedge clk);
        model_apply();
        #2;
    endtask

    // Reset pulse between edges, held across one edge carrying a command.
    task automatic pulse_reset();
        @(negedge clk);
        #1;
        load = 1'b0; call = 1'b0; ret = 1'b0; inc = 1'b1; in = 16'h5555;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_out",   32'(out),   32'h0);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_err",   32'(err),   32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        @(posedge clk);
        #1;
        chk("rst_hold_out", 32'(out), 32'h0);
        @(negedge clk);
        #1;
        inc = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] t;
        logic [WIDTH-1:0] exp_ret;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_out",   32'(out),   32'h0);
        chk("reset_empty", 32'(empty), 32'h1);
        chk("reset_full",  32'(full),  32'h0);
        chk("reset_err",   32'(err),   32'h0);
        cmp_en = 1'b1;
        #1;
        reset = 1'b0;

        // inc x3
        step(0, 1, 0, 0, 16'h0); chk("inc1", 32'(out), 32'h1);
        step(0, 1, 0, 0, 16'h0); chk("inc2", 32'(out), 32'h2);
        step(0, 1, 0, 0, 16'h0); chk("inc3", 32'(out), 32'h3);
        chk("inc_depth", 32'(depth), 32'h0);

        // load / inc / wrap
        step(1, 0, 0, 0, 16'h0371); chk("load", 32'(out), 32'h0371);
        step(0, 1, 0, 0, 16'h0);    chk("load_inc", 32'(out), 32'h0372);
        step(1, 0, 0, 0, 16'hFFFF); chk("load_ffff", 32'(out), 32'hFFFF);
        step(0, 1, 0, 0, 16'h0);    chk("wrap", 32'(out), 32'h0000);

        // nested calls and returns
        step(1, 0, 0, 0, 16'h0010);
        step(0, 0, 1, 0, 16'h0200); chk("call1", 32'(out), 32'h0200); chk("call1_d", 32'(depth), 32'h1);
        step(0, 1, 0, 0, 16'h0);    chk("call_inc", 32'(out), 32'h0201);
        step(0, 0, 1, 0, 16'h0300); chk("call2", 32'(out), 32'h0300); chk("call2_d", 32'(depth), 32'h2);
        step(0, 0, 0, 1, 16'h0);    chk("ret1", 32'(out), 32'h0202); chk("ret1_d", 32'(depth), 32'h1);
        step(0, 0, 0, 1, 16'h0);    chk("ret2", 32'(out), 32'h0011); chk("ret2_empty", 32'(empty), 32'h1);

        // overflow: eight calls to 0x1000, 0x1010, ...
        for (int k = 0; k < DEPTH; k++) begin
            t = 16'h1000 + 16'(k * 16);
            step(0, 0, 1, 0, t);
        end
        chk("ovf_full", 32'(full), 32'h1);
        step(0, 0, 1, 0, 16'hABCD);
        chk("ovf_out", 32'(out), 32'h1070);
        chk("ovf_depth", 32'(depth), 32'h8);
        chk("ovf_err", 32'(err), 32'h1);
        for (int j = 0; j < DEPTH; j++) begin
            exp_ret = (j == DEPTH - 1) ? 16'h0012 : 16'h1000 + 16'((DEPTH - 2 - j) * 16) + 16'd1;
            step(0, 0, 0, 1, 16'h0);
            chk("ovf_ret", 32'(out), 32'(exp_ret));
        end

        // underflow, sticky err, priority
        step(0, 0, 0, 1, 16'h0);    chk("unf_out", 32'(out), 32'h0012); chk("unf_err", 32'(err), 32'h1);
        step(0, 1, 0, 0, 16'h0);    chk("sticky_inc", 32'(out), 32'h0013); chk("sticky_err", 32'(err), 32'h1);
        step(0, 0, 1, 0, 16'h0500); chk("prio_call", 32'(out), 32'h0500);
        step(1, 1, 1, 1, 16'h0777); chk("prio_out", 32'(out), 32'h0014); chk("prio_d", 32'(depth), 32'h0);

        // async reset mid-sequence at depth 3, out 0x1234
        step(0, 0, 1, 0, 16'h0100);
        step(0, 0, 1, 0, 16'h0200);
        step(0, 0, 1, 0, 16'h0300);
        step(1, 0, 0, 0, 16'h1234);
        chk("pre_rst_d", 32'(depth), 32'h3);
        pulse_reset();
        step(0, 0, 0, 1, 16'h0);    chk("post_rst_unf", 32'(err), 32'h1);
        pulse_reset();

        // randomized phases alternating between push-heavy and pop-heavy bias
        for (int n = 0; n < 3000; n++) begin
            int cp, rp;
            cp = ((n / 300) % 2 == 0) ? 65 : 30;
            rp = ((n / 300) % 2 == 0) ? 15 : 45;
            if ($urandom_range(0, 249) == 0) begin
                pulse_reset();
            end else begin
                step(logic'($urandom_range(0, 99) < 20),
                     logic'($urandom_range(0, 99) < 50),
                     logic'($urandom_range(0, 99) < cp),
                     logic'($urandom_range(0, 99) < rp),
                     WIDTH'($urandom));
            end
        end

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
